// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB camera configuration sequencer.
package sccb_pkg;

    typedef enum logic [3:0] {
        PWRUP,
        IDLE,
        START,
        BITS,
        STOP,
        GAP,
        NEXT,
        DELAY,
        DONE
    } state_t;

    localparam logic [15:0] END_MARK  = 16'hFFFF;
    localparam logic [7:0]  COM7_ADDR = 8'h12;
    localparam int unsigned NUM_BITS  = 27;

    // Three-phase write: device, register, value, each followed by a released don't-care bit.
    function automatic logic [26:0] sccb_frame(input logic [7:0] dev, input logic [15:0] entry);
        return {dev, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// Combinational camera register table {reg, val}; terminated by END_MARK.
// CAM_TEST_PATTERN_EN appends the colour-bar test pattern writes.
module cam_cfg_rom
    import sccb_pkg::*;
(
    input  logic [7:0]  addr,
    output logic [15:0] data
);

    always_comb begin
        data = END_MARK;
        case (addr)
            8'd0: data = 16'h1280; // COM7 soft reset, sequencer waits afterwards
            8'd1: data = 16'h1140; // CLKRC: no prescale
            8'd2: data = 16'h1204; // COM7: RGB output
            8'd3: data = 16'h40D0; // COM15: RGB565, full range
`ifdef CAM_TEST_PATTERN_EN
            8'd4: data = 16'h703A;
            8'd5: data = 16'h71B5;
`else
`endif
            default: data = END_MARK;
        endcase
    end

endmodule

// File: rtl/sccb_cfg_seq.sv
// SCCB write sequencer: powers up the camera, then streams the cam_cfg_rom table over SIOC/SIOD.
// One write = 116 quarters of CLK_DIV cycles; CAM_TEST_PATTERN_EN extends the table.
module sccb_cfg_seq
    import sccb_pkg::*;
#(
    parameter int          CLK_DIV  = 60,
    parameter logic [7:0]  DEV_ADDR = 8'h42,
    parameter int          PWR_WAIT = 24000,
    parameter int          RST_WAIT = 24000
) (
    input  logic       CLOCK_24,
    input  logic       reset,
    input  logic       start,
    output logic       sioc,
    output logic       siod_oe,
    output logic       cam_reset,
    output logic       pwdn,
    output logic       busy,
    output logic       done,
    output logic [7:0] reg_idx
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [DIV_W-1:0]   r_div;
    logic [1:0]         r_q;
    logic [4:0]         r_bit;
    logic [31:0]        r_wait;
    logic [7:0]         r_idx;

    logic               w_qtick;
    logic [7:0]         w_rom_addr;
    logic [15:0]        w_entry;
    logic [26:0]        w_frame;
    logic [4:0]         w_bit_pos;
    logic               w_bit;

    // NEXT looks ahead one entry so the end marker never reaches the bus.
    assign w_rom_addr = (r_state == NEXT) ? r_idx + 8'd1 :
                        ((r_state == IDLE) || (r_state == DONE)) ? 8'd0 : r_idx;

    cam_cfg_rom u_rom (
        .addr (w_rom_addr),
        .data (w_entry)
    );

    assign w_qtick   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_frame   = sccb_frame(DEV_ADDR, w_entry);
    assign w_bit_pos = 5'(NUM_BITS - 1) - r_bit;
    assign w_bit     = w_frame[w_bit_pos];

    assign cam_reset = (r_state != PWRUP);
    assign pwdn      = 1'b0;
    assign busy      = r_state inside {START, BITS, STOP, GAP, NEXT, DELAY};
    assign done      = (r_state == DONE);
    assign reg_idx   = r_idx;

    always_comb begin
        w_next_state = r_state;
        sioc         = 1'b1;
        siod_oe      = 1'b0;
        case (r_state)
            PWRUP: if (r_wait == 32'(PWR_WAIT - 1)) w_next_state = IDLE;
            IDLE, DONE: begin
                if (start) w_next_state = (w_entry == END_MARK) ? DONE : START;
            end
            START: begin
                sioc    = (r_q == 2'd0);
                siod_oe = 1'b1;
                if (w_qtick && (r_q == 2'd1)) w_next_state = BITS;
            end
            BITS: begin
                sioc    = (r_q == 2'd1) || (r_q == 2'd2);
                siod_oe = ~w_bit;
                if (w_qtick && (r_q == 2'd3) && (r_bit == 5'(NUM_BITS - 1))) w_next_state = STOP;
            end
            STOP: begin
                siod_oe = (r_q == 2'd0);
                if (w_qtick && (r_q == 2'd1)) w_next_state = GAP;
            end
            GAP: begin
                if (w_qtick && (r_q == 2'd3))
                    w_next_state = ((w_entry[15:8] == COM7_ADDR) && w_entry[7]) ? DELAY : NEXT;
            end
            DELAY: if (r_wait == 32'(RST_WAIT - 1)) w_next_state = NEXT;
            NEXT: begin
                w_next_state = ((w_entry == END_MARK) || (r_idx == 8'hFF)) ? DONE : START;
            end
            default: w_next_state = PWRUP;
        endcase
    end

    always_ff @(posedge CLOCK_24 or posedge reset) begin
        if (reset) begin
            r_state <= PWRUP;
            r_div   <= '0;
            r_q     <= 2'd0;
            r_bit   <= 5'd0;
            r_wait  <= 32'd0;
            r_idx   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_div  <= '0;
                r_q    <= 2'd0;
                r_bit  <= 5'd0;
                r_wait <= 32'd0;
            end else begin
                if ((r_state == PWRUP) || (r_state == DELAY)) r_wait <= r_wait + 32'd1;
                if (w_qtick) begin
                    r_div <= '0;
                    r_q   <= r_q + 2'd1;
                    if (r_q == 2'd3) r_bit <= r_bit + 5'd1;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end
            if (((r_state == IDLE) || (r_state == DONE)) && start) r_idx <= 8'd0;
            if (r_state == NEXT) r_idx <= r_idx + 8'd1;
        end
    end

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Bench for sccb_cfg_seq: decodes the SCCB bus and scores each write against an expected-entry queue.
module tb_sccb_cfg_seq;

    localparam int CLK_DIV   = 2;
    localparam int PWR_WAIT  = 10;
    localparam int RST_WAIT  = 50;
    localparam int WRITE_CYC = 116 * CLK_DIV;

    logic       CLOCK_24 = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       sioc, siod_oe, cam_reset, pwdn, busy, done;
    logic [7:0] reg_idx;

    sccb_cfg_seq #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (8'h42),
        .PWR_WAIT (PWR_WAIT),
        .RST_WAIT (RST_WAIT)
    ) dut (
        .CLOCK_24  (CLOCK_24),
        .reset     (reset),
        .start     (start),
        .sioc      (sioc),
        .siod_oe   (siod_oe),
        .cam_reset (cam_reset),
        .pwdn      (pwdn),
        .busy      (busy),
        .done      (done),
        .reg_idx   (reg_idx)
    );

    always #5 CLOCK_24 = ~CLOCK_24;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] rom_model[$];
    logic [15:0] exp_q[$];
    int          writes = 0;
    int          busy_cnt = 0;
    int          run_id = 0;

    // bus monitor state
    logic        prev_sioc = 1'b1;
    logic        prev_oe = 1'b0;
    logic        in_frame = 1'b0;
    logic        have_prev = 1'b0;
    logic [26:0] frame = '0;
    logic [15:0] ent;
    int          nbits, cyc, t_start, t_stop, exp_gap, last_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_sequence();
        foreach (rom_model[i]) exp_q.push_back(rom_model[i]);
        run_id++;
    endtask

    function automatic int expected_busy();
        int total = 0;
        foreach (rom_model[i]) begin
            total += WRITE_CYC + 1;
            if ((rom_model[i][15:8] == 8'h12) && rom_model[i][7]) total += RST_WAIT;
        end
        return total;
    endfunction

    task automatic pulse_start();
        @(negedge CLOCK_24) start = 1'b1;
        @(negedge CLOCK_24) start = 1'b0;
    endtask

    task automatic release_and_wait_ready(input string tag);
        int n = 0;
        @(negedge CLOCK_24) reset = 1'b0;
        while (!cam_reset && n < 1000) begin
            @(posedge CLOCK_24);
            #1;
            n++;
        end
        check_eq(tag, n, PWR_WAIT);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int n = 0;
        while (writes < target && n < 4000) begin
            @(negedge CLOCK_24);
            n++;
        end
        check_eq(tag, (writes >= target), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge CLOCK_24);
            n++;
        end
        check_eq(tag, done, 1);
    endtask

    initial begin
        int w0, b0;
        rom_model.push_back(16'h1280);
        rom_model.push_back(16'h1140);
        rom_model.push_back(16'h1204);
        rom_model.push_back(16'h40D0);
`ifdef CAM_TEST_PATTERN_EN
        rom_model.push_back(16'h703A);
        rom_model.push_back(16'h71B5);
`endif
        cyc = 0; nbits = 0; t_start = 0; t_stop = 0; exp_gap = 0; last_run = 0;

        fork
            forever begin
                @(negedge CLOCK_24);
                if (run_id != last_run) begin
                    have_prev = 1'b0;
                    last_run  = run_id;
                end
                if (reset) begin
                    in_frame  = 1'b0;
                    have_prev = 1'b0;
                end else if (prev_sioc && sioc && !prev_oe && siod_oe) begin
                    if (have_prev) check_eq("inter_write_gap", cyc - t_stop, exp_gap);
                    in_frame = 1'b1;
                    nbits    = 0;
                    t_start  = cyc;
                end else if (prev_sioc && sioc && prev_oe && !siod_oe) begin
                    check_eq("stop_in_frame", in_frame, 1);
                    check_eq("sioc_rises", nbits, 28);
                    check_eq("start_to_stop", cyc - t_start, 111 * CLK_DIV);
                    check_eq("sb_has_entry", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        ent = exp_q.pop_front();
                        check_eq("dev_addr", frame[26:19], 8'h42);
                        check_eq("reg_byte", frame[17:10], ent[15:8]);
                        check_eq("val_byte", frame[8:1], ent[7:0]);
                        check_eq("dont_care", {frame[18], frame[9], frame[0]}, 3'b111);
                        exp_gap = 5 * CLK_DIV + 1 +
                                  (((ent[15:8] == 8'h12) && ent[7]) ? RST_WAIT : 0);
                    end
                    writes++;
                    in_frame  = 1'b0;
                    have_prev = 1'b1;
                    t_stop    = cyc;
                end else if (in_frame && !prev_sioc && sioc) begin
                    if (nbits < 27) frame = {frame[25:0], ~siod_oe};
                    nbits++;
                end
                if (busy) busy_cnt++;
                prev_sioc = sioc;
                prev_oe   = siod_oe;
                cyc++;
            end
        join_none

        // reset state
        repeat (3) @(posedge CLOCK_24);
        #1;
        check_eq("rst_sioc", sioc, 1);
        check_eq("rst_siod_oe", siod_oe, 0);
        check_eq("rst_cam_reset", cam_reset, 0);
        check_eq("rst_pwdn", pwdn, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_reg_idx", reg_idx, 0);

        release_and_wait_ready("pwrup_cycles");
        check_eq("idle_sioc", sioc, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);

        // full run, with a stray start pulse during the second write
        push_sequence();
        w0 = writes; b0 = busy_cnt;
        pulse_start();
        wait_writes(w0 + 1, "run1_first_write");
        repeat (100) @(negedge CLOCK_24);
        start = 1'b1;
        @(negedge CLOCK_24) start = 1'b0;
        check_eq("busy_start_ignored_idx", reg_idx, 1);
        check_eq("busy_start_ignored_busy", busy, 1);
        wait_done("run1_done");
        check_eq("run1_writes", writes - w0, rom_model.size());
        check_eq("run1_busy_cycles", busy_cnt - b0, expected_busy());
        check_eq("run1_sb_empty", exp_q.size(), 0);
        check_eq("run1_end_idx", reg_idx, rom_model.size());
        repeat (5) @(negedge CLOCK_24);
        check_eq("done_sticky", done, 1);
        check_eq("done_bus_idle", {sioc, siod_oe}, 2'b10);

        // restart from DONE, then abort with reset mid-byte
        push_sequence();
        w0 = writes;
        @(negedge CLOCK_24) start = 1'b1;
        @(posedge CLOCK_24);
        #1;
        check_eq("restart_done_clr", done, 0);
        check_eq("restart_busy", busy, 1);
        check_eq("restart_idx", reg_idx, 0);
        @(negedge CLOCK_24) start = 1'b0;
        wait_writes(w0 + 2, "run2_two_writes");
        repeat (80) @(negedge CLOCK_24);
        @(posedge CLOCK_24);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_sioc", sioc, 1);
        check_eq("abort_siod_oe", siod_oe, 0);
        check_eq("abort_cam_reset", cam_reset, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_idx", reg_idx, 0);
        exp_q.delete();
        repeat (3) @(negedge CLOCK_24);
        release_and_wait_ready("pwrup_after_abort");

        // replay after power-up
        push_sequence();
        w0 = writes; b0 = busy_cnt;
        pulse_start();
        wait_done("run3_done");
        check_eq("run3_writes", writes - w0, rom_model.size());
        check_eq("run3_busy_cycles", busy_cnt - b0, expected_busy());
        check_eq("run3_sb_empty", exp_q.size(), 0);
        check_eq("final_pwdn", pwdn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
